// File: rtl/branch_resolve_ctrl_pkg.sv
// Shared constants and types for the branch-resolve controller and its tracking queue.
// An entry is packed as {pc, pred_pc}, so it is 2*XLEN bits wide.
package branch_resolve_ctrl_pkg;

  localparam int BRC_DEPTH = 4;
  localparam int BRC_XLEN  = 32;
  localparam int BRC_CNT_W = 32;
  localparam int BRC_ENTRY_W = 2 * BRC_XLEN;

  typedef enum logic [1:0] {
    RES_IDLE = 2'd0,
    RES_HIT  = 2'd1,
    RES_MISS = 2'd2
  } resolve_t;

endpackage

// File: rtl/branch_resolve_ctrl_pred_track_fifo.sv
// In-order tracking queue of fetch-time predictions.
// The head entry is visible combinationally so EX can compare in the same cycle.
module pred_track_fifo
  import branch_resolve_ctrl_pkg::*;
#(
  parameter int DEPTH = BRC_DEPTH,
  parameter int W     = BRC_ENTRY_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clear,
  input  logic         push,
  input  logic [W-1:0] push_data,
  input  logic         pop,
  output logic [W-1:0] head_data,
  output logic         full,
  output logic         empty
);

  localparam int PW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] head;
  logic [PW-1:0] tail;
  logic [PW:0]   count;
  logic          do_push;
  logic          do_pop;

  assign full      = (count == (PW+1)'(DEPTH));
  assign empty     = (count == '0);
  assign do_push   = push && !full && !clear;
  assign do_pop    = pop && !empty && !clear;
  assign head_data = mem[head];

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[tail] <= push_data;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (rst) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else if (clear) begin
      head  <= tail;
      count <= '0;
    end else begin
      if (do_push) tail <= tail + 1'b1;
      if (do_pop)  head <= head + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/branch_resolve_ctrl.sv
// Tracks fetch-time predictions, checks them against EX-resolved next PCs,
// and produces the flush/redirect, predictor update strobe and statistics.
module branch_resolve_ctrl
  import branch_resolve_ctrl_pkg::*;
#(
  parameter int DEPTH = BRC_DEPTH,
  parameter int XLEN  = BRC_XLEN,
  parameter int CNT_W = BRC_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             fetch_valid,
  input  logic [XLEN-1:0]  fetch_pc,
  input  logic [XLEN-1:0]  fetch_pred_pc,
  output logic             fetch_ready,
  input  logic             ex_valid,
  input  logic [XLEN-1:0]  ex_pc,
  input  logic             ex_is_cf,
  input  logic [XLEN-1:0]  ex_next_pc,
  output logic             flush,
  output logic [XLEN-1:0]  redirect_pc,
  output logic             update_pred,
  output logic [XLEN-1:0]  branch_inst_address,
  output logic [XLEN-1:0]  resolved_next_pc,
  output logic             predictor_wrong,
  output logic [CNT_W-1:0] n_branches,
  output logic [CNT_W-1:0] n_mispredicts,
  output logic             order_error
);

  logic [2*XLEN-1:0] head_data;
  logic [XLEN-1:0]   head_pc;
  logic [XLEN-1:0]   head_pred_pc;
  logic              full;
  logic              empty;
  logic              push;
  logic              pop;
  logic              mispredict;
  logic              do_update;
  resolve_t          outcome;

  assign head_pc      = head_data[2*XLEN-1:XLEN];
  assign head_pred_pc = head_data[XLEN-1:0];

  assign fetch_ready = !full && !flush;
  assign push        = fetch_valid && fetch_ready;
  assign pop         = ex_valid && !empty;
  assign mispredict  = pop && (head_pred_pc != ex_next_pc);
  assign outcome     = !pop ? RES_IDLE : (mispredict ? RES_MISS : RES_HIT);
  // A non-cf mispredict is a BTB alias; the predictor still has to unlearn it.
  assign do_update   = (outcome != RES_IDLE) && (ex_is_cf || outcome == RES_MISS);

  pred_track_fifo #(
    .DEPTH (DEPTH),
    .W     (2 * XLEN)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .clear     (mispredict),
    .push      (push),
    .push_data ({fetch_pc, fetch_pred_pc}),
    .pop       (pop),
    .head_data (head_data),
    .full      (full),
    .empty     (empty)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      flush               <= 1'b0;
      redirect_pc         <= '0;
      update_pred         <= 1'b0;
      branch_inst_address <= '0;
      resolved_next_pc    <= '0;
      predictor_wrong     <= 1'b0;
      n_branches          <= '0;
      n_mispredicts       <= '0;
      order_error         <= 1'b0;
    end else begin
      flush       <= (outcome == RES_MISS);
      update_pred <= do_update;
      if (outcome == RES_MISS) begin
        redirect_pc <= ex_next_pc;
      end
      if (do_update) begin
        branch_inst_address <= head_pc;
        resolved_next_pc    <= ex_next_pc;
        predictor_wrong     <= (outcome == RES_MISS);
      end
      if (pop && ex_is_cf && (n_branches != '1)) begin
        n_branches <= n_branches + 1'b1;
      end
      if ((outcome == RES_MISS) && (n_mispredicts != '1)) begin
        n_mispredicts <= n_mispredicts + 1'b1;
      end
      if ((ex_valid && empty) || (pop && (ex_pc != head_pc))) begin
        order_error <= 1'b1;
      end
    end
  end

endmodule
